// File: rtl/joypad_serial_responder.sv
// joypad_serial_responder: controller-port parallel-in/serial-out responder; JOYPAD_TURBO_EN adds turbo on bits 0/1
module joypad_serial_responder #(
  parameter int NUM_BITS = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILL_VALUE = 1,
`ifdef JOYPAD_TURBO_EN
  parameter int TURBO_LATCHES = 2,
`endif
  localparam int CW = $clog2(NUM_BITS + 1)
)(
  input  logic                CLK,
  input  logic                n_RES,
  input  logic                OUT0_Pad,
  input  logic                nIN_Pad,
  input  logic [NUM_BITS-1:0] buttons,
`ifdef JOYPAD_TURBO_EN
  input  logic [1:0]          turbo,
`endif
  output logic                nD_Pad,
  output logic [CW-1:0]       bit_cnt
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, EXHAUSTED} state_t;
  localparam logic FILL = 1'(FILL_VALUE);
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] str_sync, nin_sync;
  logic str_s, nin_s, str_d, nin_d, nin_rise, str_fall, shift;
  logic [NUM_BITS-1:0] shreg, shreg_n, load_val;
  logic [CW-1:0] bit_cnt_n;
  assign str_s    = str_sync[SYNC_STAGES-1];
  assign nin_s    = nin_sync[SYNC_STAGES-1];
  assign nin_rise = nin_s & ~nin_d;
  assign str_fall = ~str_s & str_d;
  // strobe wins over a coincident read edge
  assign shift    = ~str_s & nin_rise;
  always_ff @(posedge CLK or negedge n_RES)
    if (!n_RES) begin
      str_sync <= '0;
      nin_sync <= '1;
      str_d    <= 1'b0;
      nin_d    <= 1'b1;
    end else begin
      str_sync <= {str_sync[SYNC_STAGES-2:0], OUT0_Pad};
      nin_sync <= {nin_sync[SYNC_STAGES-2:0], nIN_Pad};
      str_d    <= str_s;
      nin_d    <= nin_s;
    end
`ifdef JOYPAD_TURBO_EN
  localparam int LW = $clog2(TURBO_LATCHES + 1);
  logic [LW-1:0] latch_cnt;
  logic toggle;
  always_ff @(posedge CLK or negedge n_RES)
    if (!n_RES) begin
      latch_cnt <= '0;
      toggle    <= 1'b1;
    end else if (str_fall) begin
      latch_cnt <= (latch_cnt == LW'(TURBO_LATCHES - 1)) ? '0 : latch_cnt + 1'b1;
      toggle    <= (latch_cnt == LW'(TURBO_LATCHES - 1)) ? ~toggle : toggle;
    end
  always_comb begin
    load_val      = buttons;
    load_val[1:0] = buttons[1:0] & (~turbo | {2{toggle}});
  end
`else
  always_comb load_val = buttons;
`endif
  always_comb begin
    shreg_n   = str_s ? load_val : shift ? {FILL, shreg[NUM_BITS-1:1]} : shreg;
    bit_cnt_n = str_s ? '0 : (shift && bit_cnt != CW'(NUM_BITS)) ? bit_cnt + 1'b1 : bit_cnt;
    state_n   = str_s ? LOAD :
                (state == LOAD && str_fall) ? SHIFT :
                (state == SHIFT && bit_cnt_n == CW'(NUM_BITS)) ? EXHAUSTED : state;
  end
  always_ff @(posedge CLK or negedge n_RES)
    if (!n_RES) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      nD_Pad  <= 1'b1;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      nD_Pad  <= ~shreg[0];
    end
endmodule

// File: tb/tb_joypad_serial_responder.sv
// tb_joypad_serial_responder: scoreboard bench for the controller-port responder
module tb_joypad_serial_responder;
  logic CLK = 1'b0, n_RES = 1'b0, OUT0_Pad = 1'b0, nIN_Pad = 1'b1;
  logic [7:0] buttons = 8'h00;
  logic nD_Pad;
  logic [3:0] bit_cnt;
`ifdef JOYPAD_TURBO_EN
  logic [1:0] turbo = 2'b00;
`endif
  joypad_serial_responder dut (
    .CLK(CLK), .n_RES(n_RES), .OUT0_Pad(OUT0_Pad), .nIN_Pad(nIN_Pad), .buttons(buttons),
`ifdef JOYPAD_TURBO_EN
    .turbo(turbo),
`endif
    .nD_Pad(nD_Pad), .bit_cnt(bit_cnt)
  );
  always #5 CLK = ~CLK;
  logic [4:0] exp_q[$];
  string name_q[$];
  event chk;
  int n_chk = 0, n_fail = 0;
  logic [4:0] e;
  string nm;
  logic [7:0] pat;
  initial forever begin
    @(chk);
    #1;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_chk++;
      if ({nD_Pad, bit_cnt} !== e) begin
        n_fail++;
        $display("FAIL %s: got nD_Pad=%0b bit_cnt=%0d, required nD_Pad=%0b bit_cnt=%0d",
                 nm, nD_Pad, bit_cnt, e[4], e[3:0]);
      end
    end
  end
  initial begin
    #2000000;
    n_chk++;
    n_fail++;
    $display("FAIL timeout: wait expired before end of test");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic expect_out(input string s, input logic nd, input logic [3:0] cnt);
    exp_q.push_back({nd, cnt});
    name_q.push_back(s);
    ->chk;
    #2;
  endtask
  task automatic latch(input logic [7:0] b);
    buttons  = b;
    OUT0_Pad = 1'b1;
    cyc(10);
    OUT0_Pad = 1'b0;
    cyc(5);
  endtask
  task automatic read(input string s, input logic nd, input logic [3:0] cnt);
    nIN_Pad = 1'b0;
    cyc(5);
    expect_out(s, nd, cnt);
    nIN_Pad = 1'b1;
    cyc(5);
  endtask
  initial begin
    cyc(3);
    expect_out("reset", 1'b1, 4'd0);
    n_RES = 1'b1;
    cyc(2);
    read("idle_rd", 1'b1, 4'd0);
    expect_out("idle_cnt", 1'b1, 4'd1);
    pat = 8'b1000_0001;
    latch(pat);
    expect_out("basic_ld", 1'b0, 4'd0);
    for (int i = 0; i < 8; i++) read("basic", ~pat[i], 4'(i));
    expect_out("basic_end", 1'b0, 4'd8);
    for (int i = 0; i < 4; i++) read("exhaust", 1'b0, 4'd8);
    expect_out("exhaust_end", 1'b0, 4'd8);
    #1;
    n_RES = 1'b0;
    #1;
    n_chk++;
    if ({nD_Pad, bit_cnt} !== 5'b1_0000) begin
      n_fail++;
      $display("FAIL reset_state: got nD_Pad=%0b bit_cnt=%0d, required nD_Pad=1 bit_cnt=0",
               nD_Pad, bit_cnt);
    end
    expect_out("async_rst", 1'b1, 4'd0);
    cyc(2);
    n_RES = 1'b1;
    cyc(2);
    buttons  = 8'h02;
    OUT0_Pad = 1'b1;
    cyc(5);
    for (int i = 0; i < 3; i++) read("strb_hold", 1'b1, 4'd0);
    OUT0_Pad = 1'b0;
    cyc(5);
    read("strb_a", 1'b1, 4'd0);
    expect_out("strb_b", 1'b0, 4'd1);
    latch(8'hFF);
    for (int i = 0; i < 3; i++) read("relatch_ff", 1'b0, 4'(i));
    latch(8'h00);
    expect_out("relatch_ld", 1'b1, 4'd0);
    for (int i = 0; i < 8; i++) read("relatch_00", 1'b1, 4'(i));
    expect_out("relatch_end", 1'b0, 4'd8);
    nIN_Pad = 1'b0;
    cyc(3);
    latch(8'h05);
    expect_out("hold_low", 1'b0, 4'd0);
    nIN_Pad = 1'b1;
    cyc(5);
    expect_out("hold_rise", 1'b1, 4'd1);
    nIN_Pad = 1'b0;
    cyc(5);
    nIN_Pad = 1'b1;
    cyc(3);
    expect_out("lat_pre", 1'b1, 4'd2);
    cyc(1);
    expect_out("lat_post", 1'b0, 4'd2);
`ifdef JOYPAD_TURBO_EN
    n_RES = 1'b0;
    cyc(2);
    n_RES = 1'b1;
    turbo = 2'b01;
    pat = 8'b1100_1100;
    for (int k = 0; k < 8; k++) begin
      latch(8'h01);
      expect_out("turbo", pat[k], 4'd0);
    end
`endif
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
